// File: rtl/top_writeback.sv
// WriteBack stage: result select, integer register file, architectural PC and retired-instruction counter.
// Optional write-through of the retiring result onto the read ports: define WB_BYPASS_EN.
module top_writeback #(
`ifdef RV64I
  parameter int XLEN = 64,
`else
  parameter int XLEN = 32,
`endif
  parameter int OPLEN = 3,
  parameter int RF_WE_BIT = 2,
  parameter int WB_SEL_BIT_H = 1,
  parameter int WB_SEL_BIT_L = 0,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             phase_writeback,
  input  logic [OPLEN-1:0] decoded_op_mw,
  input  logic             jump_state_mw,
  input  logic [4:0]       rdsel_mw,
  input  logic [XLEN-1:0]  curr_pc_mw,
  input  logic [XLEN-1:0]  alu_out_mw,
  input  logic [XLEN-1:0]  mem_out_mw,
  input  logic [XLEN-1:0]  csr_out_mw,
  input  logic [4:0]       rs1sel,
  input  logic [4:0]       rs2sel,
  output logic [XLEN-1:0]  rs1data,
  output logic [XLEN-1:0]  rs2data,
  output logic [XLEN-1:0]  pc,
  output logic [63:0]      instret,
  output logic             inst_misaligned,
  output logic             stall_writeback
);

  logic [XLEN-1:0] regs [1:31];
  logic [1:0]      wb_sel;
  logic            wr_en;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] wr_data;
  logic [XLEN-1:0] target;

  assign wb_sel   = decoded_op_mw[WB_SEL_BIT_H:WB_SEL_BIT_L];
  assign wr_en    = phase_writeback & decoded_op_mw[RF_WE_BIT] & (rdsel_mw != 5'd0);
  assign pc_plus4 = curr_pc_mw + XLEN'(4);
  assign target   = {alu_out_mw[XLEN-1:1], 1'b0};

  assign stall_writeback = 1'b0;

  always_comb begin
    wr_data = alu_out_mw;
    case (wb_sel)
      2'b00:   wr_data = alu_out_mw;
      2'b01:   wr_data = mem_out_mw;
      2'b10:   wr_data = pc_plus4;
      default: wr_data = csr_out_mw;
    endcase
  end

  // x0 has no storage; index 0 reads as zero
  always_comb begin
    rs1data = '0;
    rs2data = '0;
    if (rs1sel != 5'd0) rs1data = regs[rs1sel];
    if (rs2sel != 5'd0) rs2data = regs[rs2sel];
`ifdef WB_BYPASS_EN
    if (wr_en && (rs1sel == rdsel_mw)) rs1data = wr_data;
    if (wr_en && (rs2sel == rdsel_mw)) rs2data = wr_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
      pc              <= RESET_VECTOR;
      instret         <= '0;
      inst_misaligned <= 1'b0;
    end else begin
      inst_misaligned <= 1'b0;
      if (phase_writeback) begin
        instret <= instret + 64'd1;
        if (!jump_state_mw) begin
          pc <= pc_plus4;
        end else if (target[1]) begin
          // misaligned target: hold at the faulting instruction and flag it
          pc              <= curr_pc_mw;
          inst_misaligned <= 1'b1;
        end else begin
          pc <= target;
        end
      end
      if (wr_en) regs[rdsel_mw] <= wr_data;
    end
  end

endmodule
